// File: rtl/l1d_rr_arb_stage.sv
// l1d_rr_arb_stage: registered round-robin arbiter for the L1D request path.
// Requesters compete through a rotating-priority search. The winner's payload is
// selected by a one-hot mux and captured in a single valid/ready output register.

// onehot_mux: AND-OR selector. The select is one-hot or zero; zero gives zero.
module onehot_mux #(
    parameter int unsigned SOURCE_COUNT = 4,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic [SOURCE_COUNT-1:0]            sel_i,
    input  logic [SOURCE_COUNT*DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0]              data_o
);

    // OR together every source gated by its select bit
    always_comb begin
        data_o = '0;
        for (int unsigned i = 0; i < SOURCE_COUNT; i++) begin
            data_o = data_o | (data_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_i[i]}});
        end
    end

endmodule

module l1d_rr_arb_stage #(
    parameter int unsigned REQ_COUNT  = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [REQ_COUNT-1:0]            req_vld_i,
    output logic [REQ_COUNT-1:0]            req_rdy_o,
    input  logic [REQ_COUNT*DATA_WIDTH-1:0] req_data_i,
    output logic                            out_vld_o,
    input  logic                            out_rdy_i,
    output logic [DATA_WIDTH-1:0]           out_data_o,
    output logic [REQ_COUNT-1:0]            out_grant_o,
    output logic [ID_WIDTH-1:0]             out_id_o
);

    logic                  out_vld_q,   out_vld_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [REQ_COUNT-1:0]  out_grant_q, out_grant_d;
    logic [ID_WIDTH-1:0]   out_id_q,    out_id_d;
    logic [ID_WIDTH-1:0]   ptr_q,       ptr_d;

    logic                  load_en;
    logic                  handshake;
    logic                  found;
    logic [REQ_COUNT-1:0]  gnt;
    logic [ID_WIDTH-1:0]   gnt_id;
    logic [DATA_WIDTH-1:0] sel_data;
    int unsigned           idx;

    // Register accepts new data when empty or draining this cycle
    assign load_en = ~out_vld_q | out_rdy_i;

    // Rotating-priority search starting at ptr_q; ptr_q is always < REQ_COUNT,
    // so a single conditional subtract handles wrap for any REQ_COUNT.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < REQ_COUNT; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= REQ_COUNT) begin
                idx = idx - REQ_COUNT;
            end
            if (!found && req_vld_i[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_WIDTH'(idx);
            end
        end
    end

    // Ready is masked during reset so no requester sees a phantom handshake
    always_comb begin
        req_rdy_o = (load_en && !rst) ? gnt : '0;
    end

    assign handshake = load_en & found;

    onehot_mux #(
        .SOURCE_COUNT (REQ_COUNT),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_onehot_mux (
        .sel_i  (gnt),
        .data_i (req_data_i),
        .data_o (sel_data)
    );

    // Next-state: load on handshake, empty on idle load slot, otherwise hold
    always_comb begin
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        out_grant_d = out_grant_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
        if (handshake) begin
            out_vld_d   = 1'b1;
            out_data_d  = sel_data;
            out_grant_d = gnt;
            out_id_d    = gnt_id;
            ptr_d       = (gnt_id == ID_WIDTH'(REQ_COUNT - 1)) ? '0 : gnt_id + ID_WIDTH'(1);
        end else if (load_en) begin
            out_vld_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset drops any held transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_grant_q <= '0;
            out_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_grant_q <= out_grant_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_vld_o   = out_vld_q;
    assign out_data_o  = out_data_q;
    assign out_grant_o = out_grant_q;
    assign out_id_o    = out_id_q;

endmodule

// File: tb/tb_l1d_rr_arb_stage.sv
// Bench for l1d_rr_arb_stage: a 4-requester instance checked against a reference
// model and transfer scoreboard, plus a 3-requester instance for wrap behaviour.
module tb_l1d_rr_arb_stage;

    logic        clk = 1'b0;
    logic        rst;

    // 4-requester instance
    logic [3:0]   vld4;
    logic [3:0]   req_rdy4;
    logic [31:0]  data4 [4];
    logic [127:0] req_data4;
    logic         out_vld4;
    logic         rdy4;
    logic [31:0]  out_data4;
    logic [3:0]   out_grant4;
    logic [1:0]   out_id4;

    // 3-requester instance
    logic [2:0]   vld3;
    logic [2:0]   req_rdy3;
    logic [47:0]  req_data3;
    logic         out_vld3;
    logic         rdy3;
    logic [15:0]  out_data3;
    logic [2:0]   out_grant3;
    logic [1:0]   out_id3;

    assign req_data4 = {data4[3], data4[2], data4[1], data4[0]};
    assign req_data3 = {16'hC002, 16'hC001, 16'hC000};

    always #5 clk = ~clk;

    l1d_rr_arb_stage #(
        .REQ_COUNT  (4),
        .DATA_WIDTH (32)
    ) dut4 (
        .clk         (clk),
        .rst         (rst),
        .req_vld_i   (vld4),
        .req_rdy_o   (req_rdy4),
        .req_data_i  (req_data4),
        .out_vld_o   (out_vld4),
        .out_rdy_i   (rdy4),
        .out_data_o  (out_data4),
        .out_grant_o (out_grant4),
        .out_id_o    (out_id4)
    );

    l1d_rr_arb_stage #(
        .REQ_COUNT  (3),
        .DATA_WIDTH (16)
    ) dut3 (
        .clk         (clk),
        .rst         (rst),
        .req_vld_i   (vld3),
        .req_rdy_o   (req_rdy3),
        .req_data_i  (req_data3),
        .out_vld_o   (out_vld3),
        .out_rdy_i   (rdy3),
        .out_data_o  (out_data3),
        .out_grant_o (out_grant3),
        .out_id_o    (out_id3)
    );

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int          id;
        logic [31:0] data;
    } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    // Reference model state for dut4
    int m_ptr;
    bit m_vld;
    int exp_k;
    bit exp_load;

    function automatic logic [3:0] exp_rdy();
        return (exp_k >= 0) ? 4'(1 << exp_k) : 4'b0000;
    endfunction

    task automatic set_payloads(input logic [15:0] tag);
        for (int j = 0; j < 4; j++) data4[j] = {tag, 16'(j)};
    endtask

    // Drive one cycle's inputs, predict the handshake, enqueue the expected transfer
    task automatic drive(input logic [3:0] vld, input logic rdy);
        sb_t e;
        vld4     = vld;
        rdy4     = rdy;
        exp_load = !m_vld || rdy;
        exp_k    = -1;
        for (int i = 0; i < 4; i++) begin
            int idx = (m_ptr + i) % 4;
            if (exp_k < 0 && vld[idx]) exp_k = idx;
        end
        if (!exp_load) exp_k = -1;
        if (exp_k >= 0) begin
            e.id   = exp_k;
            e.data = data4[exp_k];
            sb_q.push_back(e);
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (exp_k >= 0) begin
            m_ptr = (exp_k + 1) % 4;
            m_vld = 1'b1;
        end else if (exp_load) begin
            m_vld = 1'b0;
        end
    endtask

    // Scoreboard: every transfer leaving dut4 must match the oldest predicted one
    always @(negedge clk) begin
        if (!rst && out_vld4 && rdy4) begin
            n_total++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: got id %0d data %h, expected no transfer",
                         out_id4, out_data4);
            end else begin
                mon_e = sb_q.pop_front();
                if ({out_id4, out_grant4, out_data4} !==
                    {2'(mon_e.id), 4'(1 << mon_e.id), mon_e.data})
                    $display("FAIL sb_transfer: got id %0d grant %b data %h, expected id %0d grant %b data %h",
                             out_id4, out_grant4, out_data4, mon_e.id, 4'(1 << mon_e.id), mon_e.data);
                else n_pass++;
            end
        end
    end

    task automatic test_reset();
        set_payloads(16'hA000);
        rst  = 1'b1;
        vld4 = 4'b1111;
        rdy4 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #2;
            n_total++;
            if (req_rdy4 !== 4'b0000)
                $display("FAIL rst_rdy: got %b expected 0000", req_rdy4);
            else n_pass++;
        end
        n_total++;
        if ({out_vld4, out_data4, out_grant4, out_id4} !== 39'd0)
            $display("FAIL rst_values: got vld %b data %h grant %b id %0d expected all zero",
                     out_vld4, out_data4, out_grant4, out_id4);
        else n_pass++;
        rst   = 1'b0;
        m_ptr = 0;
        m_vld = 1'b0;
        sb_q.delete();
        drive(4'b1111, 1'b0);
        n_total++;
        if (req_rdy4 !== 4'b0001)
            $display("FAIL rst_first_rdy: got %b expected 0001", req_rdy4);
        else n_pass++;
        tick();
        n_total++;
        if ({out_vld4, out_id4, out_grant4, out_data4} !== {1'b1, 2'd0, 4'b0001, 32'hA000_0000})
            $display("FAIL rst_first_out: got vld %b id %0d grant %b data %h expected 1 0 0001 a0000000",
                     out_vld4, out_id4, out_grant4, out_data4);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        for (int c = 0; c < 8; c++) begin
            drive(4'b1111, 1'b1);
            tick();
            n_total++;
            if (out_id4 !== 2'((1 + c) % 4))
                $display("FAIL rr_id[%0d]: got %0d expected %0d", c, out_id4, (1 + c) % 4);
            else n_pass++;
            n_total++;
            if (out_vld4 !== 1'b1)
                $display("FAIL rr_vld[%0d]: got %b expected 1", c, out_vld4);
            else n_pass++;
        end
    endtask

    task automatic test_sparse_wrap();
        set_payloads(16'hB000);
        drive(4'b0100, 1'b1);
        tick();
        drive(4'b0000, 1'b1);
        tick();
        drive(4'b0000, 1'b1);
        tick();
        n_total++;
        if (out_vld4 !== 1'b0)
            $display("FAIL sparse_idle_vld: got %b expected 0", out_vld4);
        else n_pass++;
        drive(4'b0110, 1'b1);
        n_total++;
        if (req_rdy4 !== 4'b0010 || req_rdy4 !== exp_rdy())
            $display("FAIL sparse_rdy_ptr3: got %b expected 0010", req_rdy4);
        else n_pass++;
        tick();
        n_total++;
        if (out_id4 !== 2'd1)
            $display("FAIL sparse_id_ptr3: got %0d expected 1", out_id4);
        else n_pass++;
        for (int c = 0; c < 2; c++) begin
            drive(4'b0000, 1'b1);
            tick();
        end
        n_total++;
        if ({out_vld4, out_id4} !== {1'b0, 2'd1})
            $display("FAIL sparse_idle_hold: got vld %b id %0d expected vld 0 id 1", out_vld4, out_id4);
        else n_pass++;
        drive(4'b0011, 1'b1);
        n_total++;
        if (req_rdy4 !== 4'b0001)
            $display("FAIL sparse_rdy_ptr2: got %b expected 0001", req_rdy4);
        else n_pass++;
        tick();
        n_total++;
        if (out_id4 !== 2'd0)
            $display("FAIL sparse_id_ptr2: got %0d expected 0", out_id4);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        set_payloads(16'hC000);
        drive(4'b1111, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(4'b1111, 1'b0);
            n_total++;
            if (req_rdy4 !== 4'b0000)
                $display("FAIL bp_rdy[%0d]: got %b expected 0000", c, req_rdy4);
            else n_pass++;
            tick();
            n_total++;
            if ({out_vld4, out_id4, out_grant4, out_data4} !== {1'b1, 2'd1, 4'b0010, 32'hC000_0001})
                $display("FAIL bp_hold[%0d]: got vld %b id %0d grant %b data %h expected 1 1 0010 c0000001",
                         c, out_vld4, out_id4, out_grant4, out_data4);
            else n_pass++;
        end
        drive(4'b1111, 1'b1);
        n_total++;
        if (req_rdy4 !== 4'b0100)
            $display("FAIL bp_release_rdy: got %b expected 0100", req_rdy4);
        else n_pass++;
        tick();
        n_total++;
        if ({out_vld4, out_id4, out_data4} !== {1'b1, 2'd2, 32'hC000_0002})
            $display("FAIL bp_release_out: got vld %b id %0d data %h expected 1 2 c0000002",
                     out_vld4, out_id4, out_data4);
        else n_pass++;
        drive(4'b0000, 1'b1);
        tick();
    endtask

    task automatic test_reset_mid();
        set_payloads(16'hD000);
        drive(4'b0010, 1'b1);
        tick();
        drive(4'b1111, 1'b0);
        tick();
        rst  = 1'b1;
        vld4 = 4'b1111;
        #1;
        n_total++;
        if (req_rdy4 !== 4'b0000)
            $display("FAIL mid_rst_rdy: got %b expected 0000", req_rdy4);
        else n_pass++;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        m_ptr = 0;
        m_vld = 1'b0;
        sb_q.delete();
        n_total++;
        if (out_vld4 !== 1'b0)
            $display("FAIL mid_rst_vld: got %b expected 0", out_vld4);
        else n_pass++;
        drive(4'b1111, 1'b1);
        n_total++;
        if (req_rdy4 !== 4'b0001)
            $display("FAIL mid_rst_rdy_after: got %b expected 0001", req_rdy4);
        else n_pass++;
        tick();
        n_total++;
        if (out_id4 !== 2'd0)
            $display("FAIL mid_rst_id: got %0d expected 0", out_id4);
        else n_pass++;
        drive(4'b0000, 1'b1);
        tick();
    endtask

    task automatic test_npot();
        vld3 = 3'b111;
        rdy3 = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            #1;
            n_total++;
            if ({out_vld3, out_id3, out_grant3, out_data3} !==
                {1'b1, 2'(c % 3), 3'(1 << (c % 3)), 16'hC000 + 16'(c % 3)})
                $display("FAIL npot[%0d]: got vld %b id %0d grant %b data %h expected id %0d",
                         c, out_vld3, out_id3, out_grant3, out_data3, c % 3);
            else n_pass++;
        end
        vld3 = 3'b000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        vld4  = 4'b0000;
        rdy4  = 1'b1;
        vld3  = 3'b000;
        rdy3  = 1'b1;
        m_ptr = 0;
        m_vld = 1'b0;
        exp_k = -1;
        exp_load = 1'b0;
        set_payloads(16'h0);
        test_reset();
        test_round_robin();
        test_sparse_wrap();
        test_back_pressure();
        test_reset_mid();
        test_npot();
        n_total++;
        if (sb_q.size() != 0)
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/l1d_rr_arb_stage.md
# l1d_rr_arb_stage

Registered round-robin arbitration stage for the L1D request path. It arbitrates among `REQ_COUNT` valid/ready requesters and generates the one-hot grant vector. That vector drives an `onehot_mux` instance, which selects the winning payload. The selected payload is captured in a single pipeline register, with a valid/ready handshake, toward the downstream consumer (tag/data access stage).

## Interface
Parameters:
- `REQ_COUNT`, default 4: number of requesters; legal range 2..16.
- `DATA_WIDTH`, default 32: payload width per requester.
- `ID_WIDTH`, default `$clog2(REQ_COUNT)`: width of the binary winner index; legal minimum 1.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_vld_i`, input, `REQ_COUNT`: per-requester valid.
- `req_rdy_o`, output, `REQ_COUNT`: per-requester ready; one-hot or zero.
- `req_data_i`, input, `REQ_COUNT*DATA_WIDTH`: payloads; requester j occupies `[j*DATA_WIDTH +: DATA_WIDTH]`.
- `out_vld_o`, output, 1: output register holds a valid transaction.
- `out_rdy_i`, input, 1: downstream accepts the output this cycle.
- `out_data_o`, output, `DATA_WIDTH`: registered winning payload.
- `out_grant_o`, output, `REQ_COUNT`: registered one-hot grant of the held transaction.
- `out_id_o`, output, `ID_WIDTH`: registered binary index of the held transaction.

## Operation
- `load_en = ~out_vld_o | out_rdy_i`. The output register accepts a new transaction only when it is empty or draining in the same cycle.
- Priority pointer `ptr` (`ID_WIDTH` bits) names the highest-priority requester.
- Search order is `ptr`, `ptr+1`, …, `REQ_COUNT-1`, 0, …, `ptr-1`, with wrap-around. This must be correct for non-power-of-2 `REQ_COUNT`.
- Combinational grant `gnt` is the first requester in search order with `req_vld_i` set. `gnt` is zero if no requester is valid. `gnt` is always one-hot or zero.
- `req_rdy_o = load_en ? gnt : 0`.
- A handshake with requester k occurs when `req_vld_i[k] & req_rdy_o[k]`. At most one handshake occurs per cycle.
- Payload select: an `onehot_mux` instance with `SOURCE_COUNT=REQ_COUNT`, `DATA_WIDTH=DATA_WIDTH`, `sel_i=gnt`, and `data_i=req_data_i`.
- On a handshake with k:
  - `out_data_o`, `out_grant_o` and `out_id_o` load the new values.
  - `out_vld_o` goes to 1.
  - `ptr` goes to `(k+1) mod REQ_COUNT`.
- If `load_en` is set and there is no handshake, `out_vld_o` goes to 0. `out_data_o`, `out_grant_o` and `out_id_o` hold their last values.
- If `load_en` is 0, all registers and `ptr` hold.
- `ptr` changes only on a handshake. An idle cycle does not rotate priority.
- Requesters must not make `req_vld_i` depend on `req_rdy_o`. Once asserted, valid and data stay stable until the handshake. The block does not check this.

## Timing
- Reset values: `out_vld_o=0`, `out_data_o=0`, `out_grant_o=0`, `out_id_o=0`, `ptr=0`.
- `req_rdy_o` is 0 while `rst` is high.
- Reset asserted mid-transaction discards the held transaction. It does not complete and is not replayed.
- Latency is one cycle: a handshake in cycle N gives `out_vld_o=1` in cycle N+1.
- Throughput is one transaction per cycle while `out_rdy_i` stays high.
- Back-pressure: while `out_vld_o=1` and `out_rdy_i=0`:
  - all `req_rdy_o` are 0;
  - the output fields are held stable;
  - `ptr` is frozen.
- Simultaneous drain and load: when `out_vld_o=1`, `out_rdy_i=1` and a grant exists, the new transaction replaces the old one in the same edge with no bubble.
- Combinational paths:
  - `req_vld_i` and `out_rdy_i` to `req_rdy_o`.
  - There is no combinational path from any input to `out_*`.
- Starvation bound: a continuously valid requester wins within `REQ_COUNT` handshakes.

## Test plan
- **Reset and idle:** assert `rst` for 2 cycles with `req_vld_i=4'b1111`.
  - During reset, `req_rdy_o=0`.
  - After release, first cycle: `req_rdy_o=4'b0001`.
  - Next cycle: `out_id_o=0`, `out_grant_o=4'b0001`, `out_data_o` equals payload 0.
- **Round robin, all requesting:** `req_vld_i=4'b1111`, `out_rdy_i=1` for 8 cycles.
  - Winner ids are 0,1,2,3,0,1,2,3 on consecutive cycles.
  - `out_vld_o` stays continuously 1.
- **Sparse and wrap:** with `ptr=3`, `req_vld_i=4'b0110` → grant 1, then `ptr=2`.
  - Next request `4'b0011` → grant 0.
  - Idle cycles in between leave `ptr` unchanged.
- **Back-pressure:** hold `out_rdy_i=0` for 3 cycles with a transaction held.
  - `out_*` stay stable and `req_rdy_o=0`.
  - On `out_rdy_i=1`, the next winner loads in the same cycle.
  - No transaction is lost or duplicated; check with a scoreboard.
- **Non-power-of-2:** `REQ_COUNT=3`, all valid → ids 0,1,2,0,1,2. The pointer never reaches 3.
- **Reset mid-operation:** `out_vld_o=1`, `out_rdy_i=0`, `ptr=2`, then assert `rst` for 1 cycle.
  - `out_vld_o=0`.
  - The next grant with all valid is requester 0.
